// File: rtl/cache_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cache_ctrl
// Purpose  : Set-associative, write-through / no-write-allocate cache
//            controller driving an external data array and a memory port.
// Revision : 1.0 - initial release
// ============================================================================
module cache_ctrl #(
  parameter int WIDTH      = 8,
  parameter int WAYS       = 4,
  parameter int TOTAL_SIZE = 16,
  parameter int ADDR_W     = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            cpu_req,
  input  logic                            cpu_we,
  input  logic [ADDR_W-1:0]               cpu_addr,
  input  logic [WIDTH-1:0]                cpu_wdata,
  output logic [WIDTH-1:0]                cpu_rdata,
  output logic                            cpu_done,
  output logic                            cpu_hit,
  output logic                            cpu_busy,
  output logic                            mem_req,
  output logic                            mem_we,
  output logic [ADDR_W-1:0]               mem_addr,
  output logic [WIDTH-1:0]                mem_wdata,
  input  logic [WIDTH-1:0]                mem_rdata,
  input  logic                            mem_ack,
  output logic                            ca_we,
  output logic [$clog2(WAYS)-1:0]         ca_way,
  output logic [$clog2(TOTAL_SIZE/WAYS)-1:0] ca_index,
  output logic [WIDTH-1:0]                ca_wdata,
  input  logic [WIDTH-1:0]                ca_rdata
);

  localparam int SETS  = TOTAL_SIZE / WAYS;
  localparam int IDX_W = $clog2(SETS);
  localparam int WAY_W = $clog2(WAYS);
  localparam int TAG_W = ADDR_W - IDX_W;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOOKUP = 3'd1;
  localparam logic [2:0] S_MEM_RD = 3'd2;
  localparam logic [2:0] S_MEM_WR = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;

  logic [2:0]        state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [WIDTH-1:0]  wdata_q;
  logic [WAY_W-1:0]  victim_q;

  logic [WAYS-1:0]   valid  [SETS];
  logic [TAG_W-1:0]  tags   [SETS][WAYS];
  logic [WAY_W-1:0]  rr_ptr [SETS];

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag_in;
  logic              hit_any, inv_any;
  logic [WAY_W-1:0]  hit_way, inv_way, victim_sel;

  assign idx       = addr_q[IDX_W-1:0];
  assign tag_in    = addr_q[ADDR_W-1:IDX_W];
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign ca_index  = idx;

  // Descending scan so the lowest-numbered matching/invalid way wins.
  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    inv_any = 1'b0;
    inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid[idx][w] && (tags[idx][w] == tag_in)) begin
        hit_any = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid[idx][w]) begin
        inv_any = 1'b1;
        inv_way = WAY_W'(w);
      end
    end
  end

  assign victim_sel = inv_any ? inv_way : rr_ptr[idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (cpu_req) state_nxt = S_LOOKUP;
      S_LOOKUP: begin
        if (we_q)         state_nxt = S_MEM_WR;
        else if (hit_any) state_nxt = S_RESP;
        else              state_nxt = S_MEM_RD;
      end
      S_MEM_RD: if (mem_ack) state_nxt = S_RESP;
      S_MEM_WR: if (mem_ack) state_nxt = S_RESP;
      S_RESP:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    ca_we    = 1'b0;
    ca_way   = '0;
    ca_wdata = '0;
    cpu_done = 1'b0;
    cpu_busy = (state != S_IDLE);
    case (state)
      S_LOOKUP: begin
        if (hit_any) begin
          ca_way = hit_way;
          if (we_q) begin
            ca_we    = 1'b1;
            ca_wdata = wdata_q;
          end
        end
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ca_we    = 1'b1;
          ca_way   = victim_q;
          ca_wdata = mem_rdata;
        end
      end
      S_MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
      end
      S_RESP:   cpu_done = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      victim_q  <= '0;
      cpu_rdata <= '0;
      cpu_hit   <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        valid[s]  <= '0;
        rr_ptr[s] <= '0;
        for (int w = 0; w < WAYS; w++) tags[s][w] <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (cpu_req) begin
            addr_q  <= cpu_addr;
            we_q    <= cpu_we;
            wdata_q <= cpu_wdata;
          end
        end
        S_LOOKUP: begin
          cpu_hit  <= hit_any;
          victim_q <= victim_sel;
          if (!we_q && hit_any) cpu_rdata <= ca_rdata;
        end
        S_MEM_RD: begin
          if (mem_ack) begin
            tags[idx][victim_q]  <= tag_in;
            valid[idx][victim_q] <= 1'b1;
            rr_ptr[idx]          <= victim_q + 1'b1;
            cpu_rdata            <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cache_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_ctrl
// Purpose  : Directed self-checking bench for cache_ctrl (4-way, 4 sets).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cpu_req = 1'b0, cpu_we = 1'b0;
  logic [7:0] cpu_addr = '0, cpu_wdata = '0;
  logic [7:0] cpu_rdata;
  logic       cpu_done, cpu_hit, cpu_busy;
  logic       mem_req, mem_we;
  logic [7:0] mem_addr, mem_wdata;
  logic [7:0] mem_rdata = '0;
  logic       mem_ack = 1'b0;
  logic       ca_we;
  logic [1:0] ca_way, ca_index;
  logic [7:0] ca_wdata, ca_rdata;

  // Behavioural data array: combinational read, synchronous write.
  logic [7:0] arr [4][4];
  assign ca_rdata = arr[ca_way][ca_index];
  always @(posedge clk) if (ca_we) arr[ca_way][ca_index] <= ca_wdata;

  always #5 clk = ~clk;

  cache_ctrl #(.WIDTH(8), .WAYS(4), .TOTAL_SIZE(16), .ADDR_W(8)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_hit(cpu_hit), .cpu_busy(cpu_busy),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .ca_we(ca_we), .ca_way(ca_way), .ca_index(ca_index), .ca_wdata(ca_wdata),
    .ca_rdata(ca_rdata)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Observations recorded by do_op for the most recent request.
  logic       saw_mem, m_we, r_hit;
  logic [7:0] m_addr, m_wd, r_data, cw_wd;
  logic [1:0] cw_way, cw_idx;
  int         ca_cnt, ca_cyc, done_cyc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Issue one CPU request; memory answers dly cycles after mem_req first rises.
  task automatic do_op(input logic we, input logic [7:0] addr, input logic [7:0] wd,
                       input int dly, input logic [7:0] md);
    int  cyc, rq;
    logic done;
    saw_mem = 0; m_we = 0; m_addr = '0; m_wd = '0;
    ca_cnt = 0; ca_cyc = -1; cw_way = '0; cw_idx = '0; cw_wd = '0;
    done_cyc = -1; r_data = '0; r_hit = 0;
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    @(posedge clk); #1 cpu_req = 1'b0;
    cyc = 1; rq = 0; done = 0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      if (mem_req && rq == dly) begin
        mem_ack = 1'b1; mem_rdata = md;
      end
      #1;
      if (mem_req) begin
        if (!saw_mem) begin
          m_we = mem_we; m_addr = mem_addr; m_wd = mem_wdata;
        end
        saw_mem = 1; rq++;
      end
      if (ca_we) begin
        ca_cnt++; ca_cyc = cyc; cw_way = ca_way; cw_idx = ca_index; cw_wd = ca_wdata;
      end
      if (cpu_done) begin
        done = 1; done_cyc = cyc; r_data = cpu_rdata; r_hit = cpu_hit;
      end
      @(posedge clk); #1 mem_ack = 1'b0;
      cyc++;
    end
    if (!done) check("timeout_done", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    check("rst_busy",    cpu_busy,  0);
    check("rst_memreq",  mem_req,   0);
    check("rst_cawe",    ca_we,     0);
    check("rst_done",    cpu_done,  0);
    check("rst_rdata",   cpu_rdata, 0);
    check("rst_memaddr", mem_addr,  0);
    @(posedge clk); #1 rst = 1'b0;

    // 1: cold read miss fills way0 of set1
    do_op(0, 8'h05, 8'h00, 2, 8'hA5);
    check("t1_memreq",  saw_mem, 1);
    check("t1_memwe",   m_we,    0);
    check("t1_memaddr", m_addr,  8'h05);
    check("t1_cacnt",   ca_cnt,  1);
    check("t1_caway",   cw_way,  0);
    check("t1_caidx",   cw_idx,  1);
    check("t1_cawd",    cw_wd,   8'hA5);
    check("t1_rdata",   r_data,  8'hA5);
    check("t1_hit",     r_hit,   0);
    check("t1_lat",     done_cyc, 5);

    // 2: read hit, two-cycle latency, no memory traffic
    do_op(0, 8'h05, 8'h00, 0, 8'h00);
    check("t2_memreq", saw_mem,  0);
    check("t2_lat",    done_cyc, 2);
    check("t2_rdata",  r_data,   8'hA5);
    check("t2_hit",    r_hit,    1);
    check("t2_cacnt",  ca_cnt,   0);

    // 3: write hit updates array in LOOKUP and writes through
    do_op(1, 8'h05, 8'h3C, 1, 8'h00);
    check("t3_cacnt",   ca_cnt,  1);
    check("t3_cacyc",   ca_cyc,  1);
    check("t3_caway",   cw_way,  0);
    check("t3_caidx",   cw_idx,  1);
    check("t3_cawd",    cw_wd,   8'h3C);
    check("t3_memwe",   m_we,    1);
    check("t3_memaddr", m_addr,  8'h05);
    check("t3_memwd",   m_wd,    8'h3C);
    check("t3_hit",     r_hit,   1);
    check("t3_lat",     done_cyc, 4);
    do_op(0, 8'h05, 8'h00, 0, 8'h00);
    check("t3_rd_hit",   r_hit,   1);
    check("t3_rd_data",  r_data,  8'h3C);
    check("t3_rd_nomem", saw_mem, 0);

    // 4: write miss does not allocate
    do_op(1, 8'h09, 8'h77, 0, 8'h00);
    check("t4_cacnt",   ca_cnt, 0);
    check("t4_hit",     r_hit,  0);
    check("t4_memwe",   m_we,   1);
    check("t4_memaddr", m_addr, 8'h09);
    check("t4_memwd",   m_wd,   8'h77);
    do_op(0, 8'h09, 8'h00, 0, 8'h77);
    check("t4_rd_mem",  saw_mem, 1);
    check("t4_rd_hit",  r_hit,   0);
    check("t4_rd_way",  cw_way,  1);
    check("t4_rd_data", r_data,  8'h77);

    // 5: fill all ways of set1, then round-robin replacement
    do_reset();
    do_op(0, 8'h01, 8'h00, 0, 8'h11); check("t5_w0", cw_way, 0);
    do_op(0, 8'h05, 8'h00, 0, 8'h22); check("t5_w1", cw_way, 1);
    do_op(0, 8'h09, 8'h00, 0, 8'h33); check("t5_w2", cw_way, 2);
    do_op(0, 8'h0D, 8'h00, 1, 8'h44); check("t5_w3", cw_way, 3);
    check("t5_w3_hit", r_hit, 0);
    do_op(0, 8'h11, 8'h00, 0, 8'h55);
    check("t5_repl_way", cw_way, 0);
    check("t5_repl_hit", r_hit,  0);
    do_op(0, 8'h01, 8'h00, 0, 8'h11);
    check("t5_01_miss", r_hit,   0);
    check("t5_01_mem",  saw_mem, 1);
    check("t5_01_way",  cw_way,  1);
    do_op(0, 8'h09, 8'h00, 0, 8'h00);
    check("t5_09_hit",  r_hit,  1);
    check("t5_09_data", r_data, 8'h33);

    // 6: reset during an outstanding fill
    do_op(0, 8'h05, 8'h00, 0, 8'h66);
    check("t6_fill_way", cw_way, 2);
    do_op(0, 8'h05, 8'h00, 0, 8'h00);
    check("t6_pre_hit", r_hit, 1);
    @(posedge clk); #1 cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h15;
    @(posedge clk); #1 cpu_req = 1'b0;
    @(posedge clk); #1;
    check("t6_in_memrd", mem_req, 1);
    rst = 1'b1; #1;
    check("t6_rst_memreq", mem_req,  0);
    check("t6_rst_busy",   cpu_busy, 0);
    check("t6_rst_cawe",   ca_we,    0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk); mem_ack = 1'b1; mem_rdata = 8'hEE;
    #1;
    check("t6_late_cawe", ca_we, 0);
    @(posedge clk); #1 mem_ack = 1'b0;
    check("t6_late_busy",   cpu_busy, 0);
    check("t6_late_memreq", mem_req,  0);
    do_op(0, 8'h05, 8'h00, 0, 8'h99);
    check("t6_post_hit",  r_hit,   0);
    check("t6_post_mem",  saw_mem, 1);
    check("t6_post_way",  cw_way,  0);
    check("t6_post_data", r_data,  8'h99);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
